ring_input_buffer: RTL and testbench
====================================

Name: ring_input_buffer

Overview:
- Per-input queue that sits directly upstream of the two-requester round-robin arbiter in the ring router.
- Accepts flits from a ring link or local injection port through a valid/ready handshake and stores them in a FIFO of DEPTH entries.
- Raises a request to the arbiter whenever it holds a flit, and presents the head flit. It pops the head on the cycle the arbiter's ack is high.
- Two instances feed one arbiter (req1/ack1 and req2/ack2).

Parameters:
- DATA_WIDTH, 64, flit width in bits.
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- AW, log2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  upstream flit valid.
- in_ready  output  1  buffer can accept a flit this cycle.
- in_data  input  DATA_WIDTH  upstream flit.
- req  output  1  request to arbiter; head flit present.
- ack  input  1  grant from arbiter; combinational response to req in the same cycle.
- out_data  output  DATA_WIDTH  head flit presented to the crossbar/link mux.
- count  output  AW+1  current occupancy, 0..DEPTH.
- ack_err  output  1  sticky flag: ack seen while req low.

Behaviour:
- Reset (reset=0, asynchronous assert; deassertion sampled on clk):
  - rd_ptr, wr_ptr and count are 0.
  - req=0, in_ready=1, out_data=0, ack_err=0.
  - Storage array contents are not reset.
- push = in_valid & in_ready. The flit is written at wr_ptr on the rising edge, and wr_ptr increments modulo DEPTH (natural wrap).
- pop = req & ack. rd_ptr increments modulo DEPTH on the rising edge.
- count next value:
  - count+1 on push only.
  - count-1 on pop only.
  - unchanged on both or neither.
- in_ready = (count != DEPTH). It is registered-state derived and combinationally independent of in_valid and ack. There is no full-bypass: when full, a push is refused even if a pop occurs the same cycle.
- req = (count != 0).
- out_data = storage[rd_ptr] when count != 0, else 0.
- Latency:
  - A flit pushed at edge N gives req=1 and out_data=flit from edge N onward (cycle N+1).
  - There is no empty-to-output bypass.
- Ordering is strict FIFO. Flits are never dropped or duplicated.
- Simultaneous push and pop at any 0<count<DEPTH: both occur and count is unchanged.
- Simultaneous push and pop is impossible at count=0, because req=0 and any ack is ignored.
- Empty: req=0 and out_data=0. An ack while empty causes no pointer movement and sets ack_err.
- Full: in_ready=0, and in_valid is ignored without error; upstream must hold the flit.
- Arbiter interaction:
  - The buffer holds req and out_data stable until ack.
  - If the arbiter grants the other input, req stays high and the head is unchanged.
- ack_err is set on any cycle with ack=1 & req=0. It clears only on reset.
- Reset mid-operation: all queued flits are discarded immediately and outputs return to reset values without waiting for a clock edge.
- in_data is sampled only on push. X on in_data while in_valid=0 must not propagate.

Test Plan:
- Reset, then push A,B,C on consecutive cycles with ack=0 → count 1,2,3. req rises the cycle after A's push edge; out_data=A throughout.
- Fill DEPTH=4 with 0x11..0x44 → count=4 and in_ready=0. Hold in_valid with 0x55 and pulse ack once → 0x11 leaves and count=3. 0x55 is accepted only on the following cycle, never on the pop cycle.
- With count=2, push 0x77 and ack in the same cycle → count stays 2 and the head advances to the second flit. Draining afterwards yields exact FIFO order ending in 0x77.
- Pair two instances with the arbiter; both non-empty with continuous traffic → acks alternate every cycle (A,B,A,B starting with req1). Each buffer's count drops by 1 per grant and no flit is lost.
- Push 2*DEPTH+1 flits with interleaved pops to force pointer wrap → the output sequence matches the input sequence exactly.
- Drive ack=1 while empty → ack_err=1 and count stays 0. Assert reset=0 asynchronously mid-cycle with count=3 → req=0, count=0 and in_ready=1 before the next edge, and ack_err clears.

Source files
------------

// File: rtl/ring_input_buffer_if.sv
// Flit interface of one ring input buffer: upstream valid/ready push side,
// arbiter-facing req/ack pop side, plus occupancy and error status.
interface ring_input_buffer_if #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4
);
   localparam int AW = $clog2(DEPTH);

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  req;
   logic                  ack;
   logic [DATA_WIDTH-1:0] out_data;
   logic [AW:0]           count;
   logic                  ack_err;

   // Buffer side
   modport slave (
      input  in_valid, in_data, ack,
      output in_ready, req, out_data, count, ack_err
   );

   // Environment side: upstream link plus arbiter
   modport master (
      output in_valid, in_data, ack,
      input  in_ready, req, out_data, count, ack_err
   );
endinterface

// File: rtl/ring_input_buffer.sv
// Per-input FIFO in front of the ring router's round-robin arbiter.
// Holds up to DEPTH flits, requests the arbiter while non-empty, presents
// the head flit combinationally and pops it on the cycle ack is high.
module ring_input_buffer #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4
) (
   input  logic                clk,
   input  logic                reset,   // asynchronous, active low
   ring_input_buffer_if.slave  bus
);
   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW:0]           count_q, count_d;
   logic                  ack_err_q, ack_err_d;

   logic                  req;
   logic                  in_ready;
   logic                  push;
   logic                  pop;

   // Handshakes depend only on registered occupancy; a full buffer refuses
   // a push even if the head leaves in the same cycle.
   assign in_ready = (count_q != FULL);
   assign req      = (count_q != '0);
   assign push     = bus.in_valid & in_ready;
   assign pop      = req & bus.ack;

   // Next-state: pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      ack_err_d = ack_err_q | (bus.ack & ~req);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state; reset discards all queued flits at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         ack_err_q <= 1'b0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         ack_err_q <= ack_err_d;
      end
   end

   // Flit storage, written only on an accepted push so X data never lands
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.in_data;
   end

   assign bus.in_ready = in_ready;
   assign bus.req      = req;
   assign bus.out_data = req ? mem_q[rd_ptr_q] : '0;
   assign bus.count    = count_q;
   assign bus.ack_err  = ack_err_q;
endmodule

// File: tb/tb_ring_input_buffer.sv
// Directed + randomized bench for two ring_input_buffer instances sharing a
// behavioural round-robin arbiter; reference model is a pair of queues.
module tb_ring_input_buffer;
   localparam int DW    = 64;
   localparam int DEPTH = 4;
   typedef logic [DW-1:0] flit_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   ring_input_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();
   ring_input_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();

   ring_input_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0.slave));
   ring_input_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave));

   // Reference model
   flit_t mq0[$];
   flit_t mq1[$];
   bit    err0, err1;
   bit    arb_mode;
   int    last_grant;   // index of buffer granted most recently
   int    passed = 0;
   int    total  = 0;

   task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check_all();
      chk("b0.count",    64'(bus0.count),    64'(mq0.size()));
      chk("b0.req",      64'(bus0.req),      64'(mq0.size() != 0));
      chk("b0.in_ready", 64'(bus0.in_ready), 64'(mq0.size() != DEPTH));
      chk("b0.out_data", bus0.out_data,      (mq0.size() != 0) ? mq0[0] : '0);
      chk("b0.ack_err",  64'(bus0.ack_err),  64'(err0));
      chk("b1.count",    64'(bus1.count),    64'(mq1.size()));
      chk("b1.req",      64'(bus1.req),      64'(mq1.size() != 0));
      chk("b1.in_ready", 64'(bus1.in_ready), 64'(mq1.size() != DEPTH));
      chk("b1.out_data", bus1.out_data,      (mq1.size() != 0) ? mq1[0] : '0);
      chk("b1.ack_err",  64'(bus1.ack_err),  64'(err1));
   endtask

   task automatic idle_inputs();
      bus0.in_valid = 1'b0; bus0.in_data = 'x; bus0.ack = 1'b0;
      bus1.in_valid = 1'b0; bus1.in_data = 'x; bus1.ack = 1'b0;
   endtask

   // One clock: predict from the pre-edge model state, advance, compare
   task automatic cycle();
      bit    push0, pop0, push1, pop1;
      flit_t d0, d1;
      if (arb_mode) begin
         bit r0, r1;
         r0 = (mq0.size() != 0);
         r1 = (mq1.size() != 0);
         bus0.ack = 1'b0;
         bus1.ack = 1'b0;
         if (r0 && r1) begin
            if (last_grant == 1) begin bus0.ack = 1'b1; last_grant = 0; end
            else                 begin bus1.ack = 1'b1; last_grant = 1; end
         end else if (r0) begin bus0.ack = 1'b1; last_grant = 0; end
         else if (r1)     begin bus1.ack = 1'b1; last_grant = 1; end
      end
      push0 = (bus0.in_valid === 1'b1) && (mq0.size() != DEPTH);
      pop0  = (bus0.ack === 1'b1) && (mq0.size() != 0);
      if ((bus0.ack === 1'b1) && (mq0.size() == 0)) err0 = 1'b1;
      push1 = (bus1.in_valid === 1'b1) && (mq1.size() != DEPTH);
      pop1  = (bus1.ack === 1'b1) && (mq1.size() != 0);
      if ((bus1.ack === 1'b1) && (mq1.size() == 0)) err1 = 1'b1;
      d0 = bus0.in_data;
      d1 = bus1.in_data;
      @(posedge clk);
      #1;
      if (pop0)  void'(mq0.pop_front());
      if (push0) mq0.push_back(d0);
      if (pop1)  void'(mq1.pop_front());
      if (push1) mq1.push_back(d1);
      check_all();
   endtask

   // Asynchronous reset pulse placed mid-cycle; outputs checked before the next edge
   task automatic do_reset();
      idle_inputs();
      #3 reset = 1'b0;
      #1;
      mq0.delete(); mq1.delete();
      err0 = 1'b0; err1 = 1'b0;
      last_grant = 1;
      check_all();
      #1 reset = 1'b1;
   endtask

   function automatic flit_t rnd_flit();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      arb_mode   = 1'b0;
      last_grant = 1;
      err0 = 1'b0; err1 = 1'b0;
      idle_inputs();

      // Reset state
      #7;
      check_all();
      reset = 1'b1;

      // Push A, B, C back to back with no ack
      bus0.in_valid = 1'b1; bus0.in_data = 64'hA;
      cycle();
      bus0.in_data = 64'hB;
      cycle();
      bus0.in_data = 64'hC;
      cycle();
      idle_inputs();
      cycle();

      // Fill, then hold 0x55 while full and pulse one ack
      do_reset();
      bus0.in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         bus0.in_data = flit_t'(8'h11 * i);
         cycle();
      end
      bus0.in_data = 64'h55;
      cycle();
      bus0.ack = 1'b1;
      cycle();
      bus0.ack = 1'b0;
      cycle();
      chk("tail_after_full", 64'(mq0[mq0.size()-1]), 64'h55);

      // Drop to two entries, then simultaneous push 0x77 and pop
      idle_inputs();
      bus0.ack = 1'b1;
      cycle();
      cycle();
      bus0.in_valid = 1'b1; bus0.in_data = 64'h77;
      cycle();
      bus0.in_valid = 1'b0; bus0.in_data = 'x;
      cycle();
      cycle();
      // Ack while empty flags the error and leaves count at 0
      cycle();
      idle_inputs();
      cycle();

      // Randomized single-buffer traffic forcing many pointer wraps
      do_reset();
      for (int i = 0; i < 80; i++) begin
         bus0.in_valid = 1'($urandom_range(0, 1));
         bus0.in_data  = bus0.in_valid ? rnd_flit() : 'x;
         bus0.ack      = ($urandom_range(0, 3) != 0) && (mq0.size() != 0);
         cycle();
      end
      idle_inputs();

      // Two buffers behind a round-robin arbiter
      do_reset();
      bus0.in_valid = 1'b1; bus1.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus0.in_data = rnd_flit(); bus1.in_data = rnd_flit();
         cycle();
      end
      arb_mode = 1'b1;
      for (int i = 0; i < 60; i++) begin
         bus0.in_valid = ($urandom_range(0, 3) != 0);
         bus0.in_data  = bus0.in_valid ? rnd_flit() : 'x;
         bus1.in_valid = ($urandom_range(0, 3) != 0);
         bus1.in_data  = bus1.in_valid ? rnd_flit() : 'x;
         cycle();
      end
      bus0.in_valid = 1'b0; bus0.in_data = 'x;
      bus1.in_valid = 1'b0; bus1.in_data = 'x;
      for (int i = 0; i < 3 * DEPTH && (mq0.size() != 0 || mq1.size() != 0); i++)
         cycle();
      chk("arb_drained", 64'(bus0.count) + 64'(bus1.count), 64'd0);
      arb_mode = 1'b0;
      idle_inputs();

      // Error on one buffer, three flits in the other, then async reset
      bus1.ack = 1'b1;
      bus0.in_valid = 1'b1;
      bus0.in_data = rnd_flit();
      cycle();
      bus1.ack = 1'b0;
      bus0.in_data = rnd_flit();
      cycle();
      bus0.in_data = rnd_flit();
      cycle();
      idle_inputs();
      chk("pre_reset_count", 64'(bus0.count), 64'd3);
      do_reset();
      cycle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
